serial_to_parallel: RTL and testbench

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

---
 rtl/serial_to_parallel.sv | 110 +++++++++++
 tb/tb_serial_to_parallel.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel.sv
// serial_to_parallel
//   Assembles an N-bit word from a serial stream, LSB first, and hands it
//   to a consumer through a holding register with a valid/ack handshake.
//
//   Ports
//     CLK      in   clock, rising edge
//     N_RESET  in   synchronous active-low reset
//     EN       in   bit-sample enable; START and SIN are ignored when low
//     START    in   current SIN sample is bit 0 of a new word
//     SIN      in   serial data, LSB first
//     ACK      in   consumer has taken DATAR
//     DATAR    out  last completed word
//     VALID    out  DATAR holds an unacknowledged word
//     BUSY     out  word reception in progress
//     OVERRUN  out  sticky: a completed word was dropped
module serial_to_parallel #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic         EN,
  input  logic         START,
  input  logic         SIN,
  input  logic         ACK,
  output logic [N-1:0] DATAR,
  output logic         VALID,
  output logic         BUSY,
  output logic         OVERRUN
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t         state;
  logic [N-1:0]   sr;
  logic [CW-1:0]  cnt;

  // Every bit, including bit 0, enters at the MSB and walks right, so after
  // N samples bit 0 sits at position 0.
  logic [N-1:0] sr_shift;
  logic [N-1:0] sr_first;
  logic         done;

  assign sr_shift = {SIN, sr[N-1:1]};
  assign sr_first = {SIN, {(N-1){1'b0}}};
  // The cycle that samples bit N-1; the word is delivered on this edge.
  assign done     = (state == RECV) && EN && !START && (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (!N_RESET) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      DATAR   <= '0;
      VALID   <= 1'b0;
      BUSY    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (EN && START) begin
            sr    <= sr_first;
            cnt   <= CW'(1);
            state <= RECV;
            BUSY  <= 1'b1;
          end
        end
        RECV: begin
          if (EN) begin
            if (START) begin
              // Restart: the partial word is simply overwritten.
              sr  <= sr_first;
              cnt <= CW'(1);
            end else begin
              sr <= sr_shift;
              if (cnt == LAST) begin
                cnt   <= '0;
                state <= IDLE;
                BUSY  <= 1'b0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase

      // Holding register: an ACK in the completion cycle frees the slot in
      // time for the new word; otherwise a pending word wins and the new one
      // is dropped.
      if (done) begin
        if (!VALID || ACK) begin
          DATAR <= sr_shift;
          VALID <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (ACK && VALID) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (N=8): basic word, gapped enable,
// overrun, simultaneous ack/complete, restart, reset mid-word.
module tb_serial_to_parallel;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         N_RESET;
  logic         EN;
  logic         START;
  logic         SIN;
  logic         ACK;
  logic [N-1:0] DATAR;
  logic         VALID;
  logic         BUSY;
  logic         OVERRUN;

  int n_cmp = 0;
  int n_err = 0;

  serial_to_parallel #(.N(N)) dut (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .EN      (EN),
    .START   (START),
    .SIN     (SIN),
    .ACK     (ACK),
    .DATAR   (DATAR),
    .VALID   (VALID),
    .BUSY    (BUSY),
    .OVERRUN (OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the edge and outputs are sampled there,
  // well away from the next active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic st, input logic s, input logic ak);
    EN = en; START = st; SIN = s; ACK = ak;
  endtask

  // Send one START-framed word. Optional EN=0 gap before bit gap_at, ACK on
  // the last bit, and a quiet check (VALID=0, BUSY=1) after each early bit.
  task automatic send_word(input logic [7:0] w, input int gap_at, input int gap_len,
                           input logic ack_last, input logic quiet, input string tag);
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          drive(1'b0, 1'b0, ~w[i], 1'b0);
          tick();
          chk({tag, " gap busy"}, 32'(BUSY), 32'd1);
          chk({tag, " gap valid"}, 32'(VALID), 32'd0);
        end
      end
      drive(1'b1, (i == 0), w[i], (i == N-1) ? ack_last : 1'b0);
      tick();
      if (quiet && i < N-1) begin
        chk({tag, " quiet valid"}, 32'(VALID), 32'd0);
        chk({tag, " quiet busy"}, 32'(BUSY), 32'd1);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v,
                           input logic b, input logic o);
    chk({tag, " DATAR"}, 32'(DATAR), 32'(d));
    chk({tag, " VALID"}, 32'(VALID), 32'(v));
    chk({tag, " BUSY"}, 32'(BUSY), 32'(b));
    chk({tag, " OVERRUN"}, 32'(OVERRUN), 32'(o));
  endtask

  task automatic do_ack();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    N_RESET = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    N_RESET = 1'b1;

    // IDLE ignores START without EN, and EN without START
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("idle no-en busy", 32'(BUSY), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("idle no-start busy", 32'(BUSY), 32'd0);

    // Basic word 0xA5 (bits 1,0,1,0,0,1,0,1)
    send_word(8'hA5, -1, 0, 1'b0, 1'b1, "basic");
    check_out("basic done", 8'hA5, 1'b1, 1'b0, 1'b0);
    do_ack();
    check_out("basic ack", 8'hA5, 1'b0, 1'b0, 1'b0);

    // ACK with VALID=0 has no effect
    do_ack();
    check_out("idle ack", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Gapped enable: 3 idle-enable cycles after bit 3
    send_word(8'hA5, 4, 3, 1'b0, 1'b1, "gap");
    check_out("gap done", 8'hA5, 1'b1, 1'b0, 1'b0);
    do_ack();
    chk("gap ack valid", 32'(VALID), 32'd0);

    // Overrun: 0x3C unacked, then 0xFF is dropped
    send_word(8'h3C, -1, 0, 1'b0, 1'b0, "ovr1");
    check_out("ovr first", 8'h3C, 1'b1, 1'b0, 1'b0);
    send_word(8'hFF, -1, 0, 1'b0, 1'b0, "ovr2");
    check_out("ovr dropped", 8'h3C, 1'b1, 1'b0, 1'b1);
    do_ack();
    check_out("ovr ack", 8'h3C, 1'b0, 1'b0, 1'b1);
    do_ack();
    chk("ovr sticky", 32'(OVERRUN), 32'd1);

    // Clear OVERRUN with reset
    N_RESET = 1'b0;
    tick();
    check_out("ovr reset", 8'h00, 1'b0, 1'b0, 1'b0);
    N_RESET = 1'b1;

    // Simultaneous: VALID=1 with 0x3C, ACK on the bit-7 cycle of 0x81
    send_word(8'h3C, -1, 0, 1'b0, 1'b0, "sim1");
    check_out("sim first", 8'h3C, 1'b1, 1'b0, 1'b0);
    send_word(8'h81, -1, 0, 1'b1, 1'b0, "sim2");
    check_out("sim done", 8'h81, 1'b1, 1'b0, 1'b0);
    do_ack();
    chk("sim ack valid", 32'(VALID), 32'd0);

    // Restart after 4 bits, then full 0x5A
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), 1'b1, 1'b0);
      tick();
      chk("restart partial valid", 32'(VALID), 32'd0);
    end
    send_word(8'h5A, -1, 0, 1'b0, 1'b1, "restart");
    check_out("restart done", 8'h5A, 1'b1, 1'b0, 1'b0);

    // Reset mid-word after bit 5, with VALID=1 pending; reset beats START
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0), 1'b1, 1'b0);
      tick();
    end
    chk("pre-reset busy", 32'(BUSY), 32'd1);
    N_RESET = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("mid reset", 8'h00, 1'b0, 1'b0, 1'b0);
    N_RESET = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("post reset idle", 32'(BUSY), 32'd0);
    send_word(8'h0F, -1, 0, 1'b0, 1'b1, "after rst");
    check_out("after rst done", 8'h0F, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
